// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback unit.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO buffering long-latency writeback results.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t pop_data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written,
    // and leaving it out keeps the array mappable onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/wb_unit.sv
// Register-file writeback arbiter: ALU stream, buffered long-latency stream,
// busy scoreboard and registered write port. WB_BYPASS_EN adds forwarding ports.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              reg_write,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic [XLEN-1:0]   fwd2_data
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    wb_entry_t         lsu_entry;
    wb_entry_t         fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              starved;
    logic              alu_take;
    logic              iss_take;

    logic [SW-1:0]     starve_q,    starve_d;
    logic [NREG-1:0]   busy_q,      busy_d;
    logic              reg_write_q, reg_write_d;
    logic              from_fifo_q, from_fifo_d;
    logic [REG_AW-1:0] waddr_q,     waddr_d;
    logic [XLEN-1:0]   wdata_q,     wdata_d;

    // A head that has waited STARVE_MAX cycles steals the port from the ALU.
    assign starved   = (starve_q == STARVE_LIM);
    assign alu_ready = !starved;
    assign alu_take  = alu_valid && !starved && (alu_rd != '0);
    assign fifo_pop  = !fifo_empty && !alu_take;

    assign lsu_ready = !fifo_full;
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
    assign fifo_push = lsu_valid && !fifo_full && (lsu_rd != '0);

    assign iss_ready = !busy_q[iss_rd] || (iss_rd == '0);
    assign iss_take  = iss_valid && iss_ready && (iss_rd != '0);
    assign hazard1   = (rs1 != '0) && busy_q[rs1];
    assign hazard2   = (rs2 != '0) && busy_q[rs2];

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (lsu_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        reg_write_d = 1'b0;
        from_fifo_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        if (alu_take) begin
            reg_write_d = 1'b1;
            waddr_d     = alu_rd;
            wdata_d     = alu_data;
        end else if (fifo_pop) begin
            reg_write_d = 1'b1;
            from_fifo_d = 1'b1;
            waddr_d     = fifo_head.rd;
            wdata_d     = fifo_head.data;
        end
    end

    always_comb begin
        starve_d = starve_q + 1'b1;
        if (fifo_empty || fifo_pop) starve_d = '0;
    end

    // Busy clears once the FIFO-sourced write has landed; a new issue to the
    // same rd cannot collide because iss_ready is low while it is busy.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q && from_fifo_q) busy_d[waddr_q] = 1'b0;
        if (iss_take)                   busy_d[iss_rd]  = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q    <= '0;
            busy_q      <= '0;
            reg_write_q <= 1'b0;
            from_fifo_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            starve_q    <= starve_d;
            busy_q      <= busy_d;
            reg_write_q <= reg_write_d;
            from_fifo_q <= from_fifo_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign reg_write = reg_write_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

`ifdef WB_BYPASS_EN
    // The register file returns the old value during the write cycle.
    assign fwd1_hit  = reg_write_q && (waddr_q == rs1) && (rs1 != '0);
    assign fwd2_hit  = reg_write_q && (waddr_q == rs2) && (rs2 != '0);
    assign fwd1_data = wdata_q;
    assign fwd2_data = wdata_q;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: queue-based reference model plus directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_wb_unit;
    import wb_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  rs1, rs2;
    logic        hazard1, hazard2;
    logic        reg_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_BYPASS_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    always #5 clk = ~clk;

    wb_unit #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_rd    (iss_rd),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .reg_write (reg_write),
        .waddr     (waddr),
        .wdata     (wdata)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending long-latency results, how long the oldest has
    // been waiting, which registers are outstanding, and the write in flight.
    wb_entry_t   m_fifo[$];
    int          m_wait;
    bit [31:0]   m_busy;
    bit          e_rw;
    bit          e_from_fifo;
    bit [4:0]    e_waddr;
    bit [31:0]   e_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_wait      = 0;
        m_busy      = '0;
        e_rw        = 1'b0;
        e_from_fifo = 1'b0;
        e_waddr     = '0;
        e_wdata     = '0;
    endtask

    function automatic bit m_alu_ready();
        return !(m_fifo.size() > 0 && m_wait >= STARVE_MAX);
    endfunction

    function automatic bit m_is_busy(input logic [4:0] r);
        return (r != 0) && m_busy[r];
    endfunction

    task automatic compare();
        check("alu_ready", alu_ready, m_alu_ready());
        check("lsu_ready", lsu_ready, m_fifo.size() < DEPTH);
        check("iss_ready", iss_ready, !m_is_busy(iss_rd));
        check("hazard1",   hazard1,   m_is_busy(rs1));
        check("hazard2",   hazard2,   m_is_busy(rs2));
        check("reg_write", reg_write, e_rw);
        if (e_rw) begin
            check("waddr", waddr, e_waddr);
            check("wdata", wdata, e_wdata);
        end
`ifdef WB_BYPASS_EN
        check("fwd1_hit", fwd1_hit, e_rw && e_waddr == rs1 && rs1 != 0);
        check("fwd2_hit", fwd2_hit, e_rw && e_waddr == rs2 && rs2 != 0);
        if (e_rw) begin
            check("fwd1_data", fwd1_data, e_wdata);
            check("fwd2_data", fwd2_data, e_wdata);
        end
`endif
    endtask

    task automatic model_step();
        int        size0;
        bit        alu_wr, popped, pushed, issued;
        wb_entry_t head;
        size0  = m_fifo.size();
        alu_wr = alu_valid && m_alu_ready() && alu_rd != 0;
        popped = !alu_wr && size0 > 0;
        pushed = lsu_valid && size0 < DEPTH && lsu_rd != 0;
        issued = iss_valid && iss_rd != 0 && !m_busy[iss_rd];
        if (e_rw && e_from_fifo) m_busy[e_waddr] = 1'b0;
        if (issued) m_busy[iss_rd] = 1'b1;
        head = '0;
        if (popped) head = m_fifo.pop_front();
        if (alu_wr) begin
            e_rw = 1'b1; e_from_fifo = 1'b0; e_waddr = alu_rd; e_wdata = alu_data;
        end else if (popped) begin
            e_rw = 1'b1; e_from_fifo = 1'b1; e_waddr = head.rd; e_wdata = head.data;
        end else begin
            e_rw = 1'b0; e_from_fifo = 1'b0;
        end
        if (pushed) m_fifo.push_back('{rd: lsu_rd, data: lsu_data});
        m_wait = (size0 == 0 || popped) ? 0 : m_wait + 1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic rand_inputs();
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
        iss_valid = ($urandom_range(0, 99) < 30);
        iss_rd    = 5'($urandom_range(0, 7));
        lsu_valid = ($urandom_range(0, 99) < 50);
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_data  = $urandom;
        rs1       = 5'($urandom_range(0, 7));
        rs2       = 5'($urandom_range(0, 7));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_write"}, reg_write, 0);
        check({tag, "_waddr"},     waddr,     0);
        check({tag, "_wdata"},     wdata,     0);
        check({tag, "_alu_ready"}, alu_ready, 1);
        check({tag, "_lsu_ready"}, lsu_ready, 1);
        check({tag, "_iss_ready"}, iss_ready, 1);
        check({tag, "_hazard1"},   hazard1,   0);
        check({tag, "_hazard2"},   hazard2,   0);
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1ns later.
    task automatic step();
        #1;
        if (reset_n) begin
            compare();
            model_step();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int stall_cnt;
        int stall_at;

        reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            #1;
            check_reset_outputs("rst");
            @(negedge clk);
        end
        idle();
        reset_n = 1'b1;
        step();

        // Single ALU write lands exactly one cycle later.
        idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; step();
        idle(); #1;
        check("alu_wr_en",   reg_write, 1);
        check("alu_wr_addr", waddr,     5);
        check("alu_wr_data", wdata,     32'hDEADBEEF);
        step();
        idle(); #1; check("alu_wr_once", reg_write, 0); step();

        // Scoreboard: issue rd=7 in c0, LSU result in c3, write c5, clear c6.
        idle(); iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; #1;
        check("sb_c0_iss_ready", iss_ready, 1);
        check("sb_c0_hazard1",   hazard1,   0);
        step();
        idle(); iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; #1;
        check("sb_c1_hazard1",   hazard1,   1);
        check("sb_c1_iss_ready", iss_ready, 0);
        step();
        idle(); rs1 = 5'd7; step();
        idle(); rs1 = 5'd7; lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234; step();
        idle(); rs1 = 5'd7; #1; check("sb_c4_hazard1", hazard1, 1); step();
        idle(); rs1 = 5'd7; #1;
        check("sb_c5_reg_write", reg_write, 1);
        check("sb_c5_waddr",     waddr,     7);
        check("sb_c5_wdata",     wdata,     32'h1234);
        check("sb_c5_hazard1",   hazard1,   1);
        step();
        idle(); rs1 = 5'd7; #1; check("sb_c6_hazard1", hazard1, 0); step();

        // Starvation: continuous ALU traffic, one LSU result for rd=9.
        stall_cnt = 0;
        stall_at  = -1;
        idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999;
        step();
        for (int c = 1; c <= 8; c++) begin
            idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(c); #1;
            if (!alu_ready) begin
                stall_cnt++;
                stall_at = c;
            end
            if (c == 6) begin
                check("starve_head_write", reg_write, 1);
                check("starve_head_waddr", waddr,     9);
                check("starve_head_wdata", wdata,     32'h9999);
            end
            if (c == 7) begin
                check("starve_alu_resume_waddr", waddr, 1);
                check("starve_alu_resume_wdata", wdata, 6);
            end
            step();
        end
        check("starve_stall_count", stall_cnt, 1);
        check("starve_stall_cycle", stall_at,  5);

        // FIFO full under continuous ALU writes, then an x0 ALU op frees the port.
        idle(); alu_valid = 1'b1; alu_rd = 5'd2;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAAAA0010; step();
        idle(); alu_valid = 1'b1; alu_rd = 5'd2;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hAAAA0011; #1;
        check("full_c1_lsu_ready", lsu_ready, 1);
        step();
        idle(); alu_valid = 1'b1; alu_rd = 5'd2;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hAAAA0012; #1;
        check("full_c2_lsu_ready", lsu_ready, 0);
        step();
        idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF0000; #1;
        check("x0_alu_ready", alu_ready, 1);
        step();
        idle(); #1;
        check("x0_pop_write", reg_write, 1);
        check("x0_pop_waddr", waddr,     10);
        check("x0_pop_wdata", wdata,     32'hAAAA0010);
        check("x0_lsu_ready", lsu_ready, 1);
        step();
        idle(); #1; check("drain_waddr", waddr, 11); step();
        idle(); step();
        idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678; step();
        idle(); #1; check("x0_no_write", reg_write, 0); step();

`ifdef WB_BYPASS_EN
        idle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5A5A5; step();
        idle(); rs1 = 5'd4; rs2 = 5'd3; #1;
        check("byp_fwd2_hit",  fwd2_hit,  1);
        check("byp_fwd2_data", fwd2_data, 32'hA5A5A5A5);
        check("byp_fwd1_hit",  fwd1_hit,  0);
        step();
`endif

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        // Asynchronous reset in the middle of a cycle.
        rand_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rand_inputs();
        #1;
        check_reset_outputs("mid_rst_hold");
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback unit driving the single write port of the 32x32 integer register file: reg_write, waddr, wdata. Arbitrates between a single-cycle ALU result stream and a long-latency result stream (load/mul/div), buffering the latter in a small FIFO. Keeps a per-register busy scoreboard for outstanding long-latency destinations and reports read hazards to decode.

## Interface
Parameters:
- DEPTH, 2: long-latency FIFO entries; power of two, at least 2.
- STARVE_MAX, 4: cycles a FIFO head may wait before the ALU is back-pressured.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid / alu_ready  in / out  1 / 1  ALU result handshake.
- alu_rd, alu_data  in  5, 32  ALU destination and value.
- iss_valid / iss_ready  in / out  1 / 1  long-latency op issue; marks destination busy.
- iss_rd  in  5  issued destination.
- lsu_valid / lsu_ready  in / out  1 / 1  long-latency result handshake.
- lsu_rd, lsu_data  in  5, 32  long-latency destination and value.
- rs1, rs2  in  5  decode source indices.
- hazard1, hazard2  out  1  source register is busy.
- reg_write, waddr, wdata  out  1, 5, 32  register file write port; registered.

## Operation
- Transfer occurs when valid && ready are both high at a rising edge.
- ALU accepted with rd!=0: it is the write for the next cycle. ALU accepted with rd==0: consumed, no write.
- LSU accepted with rd!=0: pushed to the FIFO. LSU accepted with rd==0: consumed, not pushed.
- FIFO pop happens when FIFO is non-empty and no ALU write is taken that cycle. The popped entry is the next write.
- lsu_ready = !full. iss_ready = !busy[iss_rd] || iss_rd==0.
- Starvation counter:
  - counts cycles the FIFO is non-empty without a pop; cleared on pop or when empty;
  - when it equals STARVE_MAX, alu_ready=0 for that cycle and the head pops.
- Scoreboard busy[31:1]:
  - set on accepted issue with iss_rd!=0;
  - cleared at the edge that ends the reg_write cycle of a FIFO-sourced write to that rd;
  - ALU writes never change busy.
- hazardN = (rsN!=0) && busy[rsN]; combinational from registered busy.
- ALU writes to a busy register are performed. Avoiding this WAW case is upstream's responsibility.

## Timing
- Reset values:
  - reg_write=0, waddr=0, wdata=0, busy=0, FIFO empty, starvation counter=0;
  - alu_ready=1, lsu_ready=1, iss_ready=1, hazards=0 while reset_n is low.
- ALU latency: accept in cycle N → reg_write in N+1; register file updated at end of N+1.
- LSU latency: push in N → earliest pop in N+1 → reg_write in N+2 → hazard deasserts in N+3.
- Issue accepted in N → hazard visible from N+1.
- FIFO full: lsu_ready=0. Pop and push in the same cycle are allowed when not full; count is unchanged.
- Reset mid-operation discards FIFO contents, the pending write and all busy bits immediately.

## Configuration
- WB_BYPASS_EN defined: adds fwd1_hit, fwd2_hit (1 bit) and fwd1_data, fwd2_data (32 bit).
  - fwdN_hit = reg_write && waddr==rsN && rsN!=0.
  - fwdN_data = wdata.
  - This forwards the value being written in the current cycle, which the register file does not yet return.
- Undefined: these ports do not exist and decode must wait one cycle after the write.

## Structure
- Shared package wb_pkg holds:
  - XLEN=32 and REG_AW=5;
  - wb_entry_t struct {rd, data}.
- Sub-module wb_fifo holds the DEPTH-entry, wb_entry_t-wide synchronous FIFO with push, pop, full and empty, reset by reset_n.
- wb_unit contains the arbiter, starvation counter, scoreboard and output register.

## Test plan
- Reset: hold reset_n=0 with random inputs → reg_write=0, waddr=0, wdata=0, all ready outputs 1, hazards 0.
- ALU write: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 0 → reg_write=1, waddr=5, wdata=0xDEADBEEF in cycle 1 only.
- Scoreboard path:
  - issue rd=7 in cycle 0 with rs1=7 → hazard1=1 from cycle 1 and iss_ready=0 for iss_rd=7;
  - LSU push rd=7, 0x1234 in cycle 3 → write in cycle 5, hazard1=0 in cycle 6.
- Starvation: ALU valid every cycle with rd=1, one LSU push rd=9, STARVE_MAX=4 → alu_ready=0 in exactly one cycle, rd=9 written the next cycle, ALU writes resume.
- Full and x0:
  - DEPTH=2, ALU continuous, two LSU pushes → lsu_ready=0;
  - ALU rd=0 → no reg_write, and the FIFO head pops that cycle.
- WB_BYPASS_EN: reg_write of rd=3, 0xA5A5A5A5 while rs2=3 → fwd2_hit=1, fwd2_data=0xA5A5A5A5, fwd1_hit=0.
